reg_rename_file: RTL
====================

# reg_rename_file

Architectural register file with per-register ROB rename tags, sitting between the decoder and the reorder buffer. It accepts committed results from the ROB head and records each newly dispatched destination register's ROB tag. For each decoded instruction it answers the decoder's two source-operand queries combinationally. Each answer is a ready value, or the ROB tag to wait on, resolved against the ROB's same-cycle dependency answers. A ROB flush drops all rename tags and keeps committed values.

## Interface
- ROB_WIDTH_BIT, 5: ROB index width; tags are ROB_WIDTH_BIT bits.
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; state holds when low.
- clear_in  input  1  ROB flush (mispredict), sampled with rdy_in.
- commit_reg_id  input  5  committing destination; 0 = no commit.
- commit_val  input  32  committed value.
- commit_rob_id  input  ROB_WIDTH_BIT  ROB index of the committing entry.
- new_reg_id  input  5  destination being renamed this cycle; 0 = none.
- new_rob_id  input  ROB_WIDTH_BIT  ROB tail index assigned to it.
- rs1_id, rs2_id  input  5 each  decoder source register queries.
- rob_rs1_id, rob_rs2_id  output  ROB_WIDTH_BIT each  tag forwarded to the ROB lookup = tag[rsN_id].
- rob_rs1_ready, rob_rs2_ready  input  1 each  ROB reports entry value available.
- rob_rs1_val, rob_rs2_val  input  32 each  ROB entry value.
- rs1_dep, rs2_dep  output  1 each  1 = operand pending; consumer waits on rsN_tag.
- rs1_val, rs2_val  output  32 each  operand value; valid when rsN_dep = 0, else 0.
- rs1_tag, rs2_tag  output  ROB_WIDTH_BIT each  producing ROB index when rsN_dep = 1, else 0.

## Operation
- State: value[0..31] (32 b), busy[0..31], tag[0..31]. Register 0 reads 0, is never busy, and ignores writes.
- Query (per source N, combinational, priority order):
  - rsN_id == 0 → dep 0, val 0.
  - Not busy → dep 0, val = value[rsN_id], with commit bypass: if commit_reg_id == rsN_id ≠ 0 then val = commit_val.
  - Busy and commit_rob_id == tag and commit_reg_id == rsN_id → dep 0, val = commit_val.
  - Busy and rob_rsN_ready → dep 0, val = rob_rsN_val.
  - Otherwise → dep 1, tag = tag[rsN_id], val 0.
- Queries see state before this cycle's rename. A same-cycle new_reg_id == rsN_id does not affect the answer, so "addi x1,x1,1" reads the old x1.
- Commit (rdy_in = 1, clear_in = 0, commit_reg_id ≠ 0):
  - value[rd] ← commit_val.
  - busy[rd] ← 0 only if tag[rd] == commit_rob_id and rd is not being renamed this cycle.
- Rename (rdy_in = 1, clear_in = 0, new_reg_id ≠ 0): busy ← 1, tag ← new_rob_id. Rename wins over a commit-clear of the same register.
- Flush (rdy_in = 1, clear_in = 1):
  - All busy ← 0 and all tag ← 0.
  - That cycle's commit and rename are ignored, because they belong to the wrong path.
  - value[] is retained.
- rdy_in = 0: no state change. Combinational outputs stay live.

## Timing
- Queries: zero-cycle combinational, including the ROB round trip through rob_rsN_id → rob_rsN_ready/val.
- Commit, rename and flush take effect at the next rising clk_in.
- Asynchronous reset (rst_n_in = 0), immediate:
  - value, busy and tag all become 0.
  - All outputs read dep 0, val 0, tag 0; rob_rsN_id = 0.
- Reset released mid-operation resumes from that all-zero state. No pending rename survives reset.
- Commit and rename may target the same register in one cycle: value is written, busy stays 1, and tag becomes new_rob_id.
- Tag wrap-around: tags are compared exactly. A stale commit whose ROB index differs from the current tag never clears busy.

## Test plan
- Reset, then rename x5→tag 3; query rs1 = 5 with rob_rs1_ready = 0 → rs1_dep = 1, rs1_tag = 3. Commit (5, 0xDEAD, 3) → next cycle x5 not busy; query → dep 0, val 0xDEAD.
- Rename x7→tag 4, then x7→tag 9; commit (7, 0x11, 4) → x7 stays busy with tag 9. Query with rob_rs1_ready = 1, rob_rs1_val = 0x22 → dep 0, val 0x22.
- Same cycle: commit (2, 0x55, 6) with x2 tag 6, query rs2 = 2, and rename x2→tag 8 → rs2 = 0x55, dep 0. Next cycle x2 is busy with tag 8 and value 0x55.
- Rename x1, x3, x4 to tags 1, 2, 3; pulse clear_in together with commit (3, 0x99, 2) → no register busy, value[3] unchanged, queries return the old values.
- With rdy_in = 0, commit and rename to x6 → no change. Query x0 after commit (0, 0xFFFF_FFFF, 1) → val 0, dep 0.
- Assert rst_n_in asynchronously mid-cycle while x9 is busy → outputs drop to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags.
// Source queries resolve combinationally against commit bypass and the ROB's same-cycle answers.
module reg_rename_file #(
  parameter int unsigned ROB_WIDTH_BIT = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic [4:0]               commit_reg_id,
  input  logic [31:0]              commit_val,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [4:0]               new_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] new_rob_id,
  input  logic [4:0]               rs1_id,
  input  logic [4:0]               rs2_id,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
  input  logic                     rob_rs1_ready,
  input  logic                     rob_rs2_ready,
  input  logic [31:0]              rob_rs1_val,
  input  logic [31:0]              rob_rs2_val,
  output logic                     rs1_dep,
  output logic                     rs2_dep,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
  output logic [ROB_WIDTH_BIT-1:0] rs2_tag
);

  typedef struct packed {
    logic                     dep;
    logic [31:0]              val;
    logic [ROB_WIDTH_BIT-1:0] tag;
  } ans_t;

  logic [31:0]              value_q [32];
  logic                     busy_q  [32];
  logic [ROB_WIDTH_BIT-1:0] tag_q   [32];

  ans_t ans1, ans2;

  function automatic ans_t resolve(input logic [4:0]  id,
                                   input logic        rob_ready,
                                   input logic [31:0] rob_val);
    ans_t a;
    a = '0;
    if (id == 5'd0) begin
      a = '0;
    end else if (!busy_q[id]) begin
      a.val = (commit_reg_id == id) ? commit_val : value_q[id];
    end else if (commit_rob_id == tag_q[id] && commit_reg_id == id) begin
      a.val = commit_val;
    end else if (rob_ready) begin
      a.val = rob_val;
    end else begin
      a.dep = 1'b1;
      a.tag = tag_q[id];
    end
    return a;
  endfunction

  always_comb begin
    ans1 = resolve(rs1_id, rob_rs1_ready, rob_rs1_val);
    ans2 = resolve(rs2_id, rob_rs2_ready, rob_rs2_val);
  end

  // Outputs forced to zero while reset is held, even if a commit is on the bypass path.
  always_comb begin
    if (!rst_n_in) begin
      rob_rs1_id = '0;
      rob_rs2_id = '0;
      rs1_dep    = 1'b0;
      rs2_dep    = 1'b0;
      rs1_val    = '0;
      rs2_val    = '0;
      rs1_tag    = '0;
      rs2_tag    = '0;
    end else begin
      rob_rs1_id = tag_q[rs1_id];
      rob_rs2_id = tag_q[rs2_id];
      rs1_dep    = ans1.dep;
      rs2_dep    = ans2.dep;
      rs1_val    = ans1.val;
      rs2_val    = ans2.val;
      rs1_tag    = ans1.tag;
      rs2_tag    = ans2.tag;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (clear_in) begin
        for (int i = 0; i < 32; i++) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end else begin
        if (commit_reg_id != 5'd0) begin
          value_q[commit_reg_id] <= commit_val;
          // Only the commit matching the current tag releases the register.
          if (tag_q[commit_reg_id] == commit_rob_id && new_reg_id != commit_reg_id) begin
            busy_q[commit_reg_id] <= 1'b0;
          end
        end
        if (new_reg_id != 5'd0) begin
          busy_q[new_reg_id] <= 1'b1;
          tag_q[new_reg_id]  <= new_rob_id;
        end
      end
    end
  end

endmodule
